y_job_sched: RTL and testbench
==============================

// Module: y_job_sched
// PURPOSE
//  Upstream operand scheduler and downstream result collector for compute_y.
//  Buffers (a,b) operand pairs arriving on a valid/ready stream in a small FIFO.
//  Issues each pair to compute_y with a one-cycle start pulse and holds the operands stable.
//  Captures y on compute_y's ready pulse and presents {a,b,y} on a valid/ready result stream.
//  A watchdog flags a compute_y that never answers.
// PARAMETERS
//  DATA_W      8     width of a, b and y
//  FIFO_DEPTH  4     operand FIFO entries; power of 2, >=2
//  TIMEOUT     1023  max cycles in WAIT before fault; >=2
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         reset, asynchronous, active-low
//  in_valid   in   1         operand pair valid
//  in_ready   out  1         FIFO can accept a pair
//  in_a       in   DATA_W    operand a
//  in_b       in   DATA_W    operand b
//  y_start    out  1         start pulse to compute_y
//  y_a        out  DATA_W    operand a to compute_y
//  y_b        out  DATA_W    operand b to compute_y
//  y_in       in   DATA_W    compute_y result
//  y_ready    in   1         compute_y done pulse, one cycle
//  out_valid  out  1         result valid
//  out_ready  in   1         result consumer ready
//  out_a      out  DATA_W    echo of operand a
//  out_b      out  DATA_W    echo of operand b
//  out_y      out  DATA_W    result
//  out_err    out  1         result produced by timeout, not by compute_y
//  fault      out  1         sticky watchdog fault
//  fifo_count out  $clog2(FIFO_DEPTH)+1  stored pairs
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, FIFO empty, fifo_count=0.
//   All outputs are 0 immediately, including in_ready. in_ready=1 from the first edge after release.
//  FIFO: in_ready = !fault && fifo_count<FIFO_DEPTH. Push on in_valid&&in_ready.
//   Full: no push, even if a pop occurs in the same cycle. Push and pop in the same cycle: count unchanged.
//   Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
//  FSM (registered):
//   IDLE: if fifo_count!=0 && !out_valid, pop head into a_q/b_q, go to ISSUE.
//   ISSUE: y_start=1 for exactly this one cycle. Clear the timer. Go to WAIT.
//   WAIT: timer++.
//    On y_ready=1: out_y<=y_in, out_a<=a_q, out_b<=b_q, out_err<=0, out_valid<=1, go to IDLE.
//    Else if timer==TIMEOUT-1: out_y<=all ones, out_err<=1, out_valid<=1, fault<=1, go to HALT.
//   HALT: in_ready=0, no further issue. Leaves only via reset. Pending FIFO entries are discarded by reset.
//  y_a/y_b = a_q/b_q. They are stable from ISSUE through the y_ready cycle because compute_y reads operands continuously.
//  y_ready outside WAIT is ignored.
//  Result stream: out_* are held stable while out_valid && !out_ready.
//   out_valid clears on the handshake edge.
//   Only one job is in flight. The next pop waits for out_valid=0, which gives at least 2 cycles between y_ready and the next y_start.
//  Latency: pair pushed at edge E0 into an empty, idle block gives pop at E1 and y_start high during E1..E2.
//   out_valid rises at the edge after y_ready is sampled high.
//  Arithmetic: none. y_in passes through unmodified; DATA_W wrap is compute_y's.
//  Mid-operation reset: job abandoned, no result emitted. compute_y is reset by the same system reset.
// TESTING
//  1. a=3,b=8, compute_y model returns 11 -> one y_start pulse; out_valid with out_a=3, out_b=8, out_y=11, out_err=0.
//  2. Model stalled; 6 pairs offered on consecutive cycles -> 5 accepted (1 popped + 4 stored), in_ready=0 on the 6th.
//     After release, results emerge in push order.
//  3. out_ready=0 for 50 cycles after first result -> out_* stable, no second y_start; second y_start follows the handshake.
//  4. a=16,b=1, model returns 8'd1 (257 wrapped) -> out_y=1, out_err=0.
//  5. TIMEOUT=16, model never pulses y_ready -> 16 cycles after ISSUE: out_valid, out_y=8'hFF, out_err=1, fault=1, in_ready=0 until reset.
//  6. rst low mid-WAIT, between clock edges -> outputs 0 at once, fifo_count=0. After release a new pair completes normally.

Source files
------------

// File: rtl/y_job_sched.sv
// Operand scheduler and result collector for compute_y: buffers (a,b) pairs,
// issues one job at a time, captures y and guards against a silent compute_y.
module y_job_sched #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_a,
  input  logic [DATA_W-1:0]           in_b,
  output logic                        y_start,
  output logic [DATA_W-1:0]           y_a,
  output logic [DATA_W-1:0]           y_b,
  input  logic [DATA_W-1:0]           y_in,
  input  logic                        y_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_a,
  output logic [DATA_W-1:0]           out_b,
  output logic [DATA_W-1:0]           out_y,
  output logic                        out_err,
  output logic                        fault,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] mem_a [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              running;
  logic              push;
  logic              pop;
  logic              done;
  logic              timeout;

  // running keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) running <= 1'b0;
    else      running <= 1'b1;
  end

  assign in_ready   = running && !fault && (count < CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0) && !out_valid;
  assign done       = (state == WAIT) && y_ready;
  assign timeout    = (state == WAIT) && !y_ready && (timer == TMR_W'(TIMEOUT - 1));
  assign fifo_count = count;
  assign y_a        = a_q;
  assign y_b        = b_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (done)         state_nxt = IDLE;
        else if (timeout) state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    y_start = (state == ISSUE);
  end

  // a_q/b_q stay put from the pop until the next pop, covering ISSUE..y_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      timer <= '0;
    end else begin
      if (pop) begin
        a_q <= mem_a[rd_ptr];
        b_q <= mem_b[rd_ptr];
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_y     <= '0;
      out_err   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (done) begin
        out_valid <= 1'b1;
        out_a     <= a_q;
        out_b     <= b_q;
        out_y     <= y_in;
        out_err   <= 1'b0;
      end else if (timeout) begin
        out_valid <= 1'b1;
        out_a     <= a_q;
        out_b     <= b_q;
        out_y     <= '1;
        out_err   <= 1'b1;
        fault     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_y_job_sched.sv
// Bench for y_job_sched: directed scenarios and random traffic against a
// queue of expected jobs and a behavioural compute_y stand-in.
module tb_y_job_sched;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic              y_start;
  logic [DATA_W-1:0] y_a;
  logic [DATA_W-1:0] y_b;
  logic [DATA_W-1:0] y_in = '0;
  logic              y_ready = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_y;
  logic              out_err;
  logic              fault;
  logic [CNT_W-1:0]  fifo_count;

  typedef struct {
    int a;
    int b;
    int y;
  } job_t;

  job_t        exp_q[$];
  int          rd_idx       = 0;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          start_count  = 0;
  int          ready_mode   = 0;
  bit          model_hold   = 1'b0;
  bit          model_force  = 1'b0;
  bit          mon_en       = 1'b1;
  bit          model_busy   = 1'b0;
  int          model_wait   = 0;
  logic        prev_start   = 1'b0;
  logic [7:0]  cap_a        = '0;
  logic [7:0]  cap_b        = '0;
  logic [8:0]  force_val    = 9'd257;

  y_job_sched #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .y_start    (y_start),
    .y_a        (y_a),
    .y_b        (y_b),
    .y_in       (y_in),
    .y_ready    (y_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_y      (out_y),
    .out_err    (out_err),
    .fault      (fault),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // compute_y stand-in: latches operands on y_start, answers after a random delay
  task automatic model_tick();
    y_ready = 1'b0;
    if (!rst) begin
      model_busy = 1'b0;
      prev_start = 1'b0;
      return;
    end
    if (model_busy && !model_hold) begin
      if (model_wait == 0) begin
        checkOutput("y_a_stable", 32'(y_a), 32'(cap_a));
        checkOutput("y_b_stable", 32'(y_b), 32'(cap_b));
        y_in       = model_force ? force_val[7:0] : cap_a + cap_b;
        y_ready    = 1'b1;
        model_busy = 1'b0;
      end else begin
        model_wait--;
      end
    end
    if (y_start === 1'b1) begin
      checkOutput("y_start_width", 32'(prev_start), 32'd0);
      checkOutput("one_in_flight", 32'(model_busy), 32'd0);
      start_count++;
      cap_a      = y_a;
      cap_b      = y_b;
      model_busy = 1'b1;
      model_wait = $urandom_range(0, 3);
    end
    prev_start = y_start;
  endtask

  task automatic monitor();
    if (!rst) begin
      rd_idx = exp_q.size();
      return;
    end
    if (mon_en && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (rd_idx >= exp_q.size()) begin
        checkOutput("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("out_a", 32'(out_a), exp_q[rd_idx].a);
        checkOutput("out_b", 32'(out_b), exp_q[rd_idx].b);
        checkOutput("out_y", 32'(out_y), exp_q[rd_idx].y);
        checkOutput("out_err", 32'(out_err), 32'd0);
        rd_idx++;
      end
    end
  endtask

  // One clock: model/consumer act just after the edge, monitor samples on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    model_tick();
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic applyStimulus(input int a, input int b, input int y_exp);
    bit accepted = 1'b0;
    job_t j;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    for (int n = 0; n < 60 && !accepted; n++) begin
      if (in_ready === 1'b1) begin
        j.a = a;
        j.b = b;
        j.y = y_exp;
        exp_q.push_back(j);
        accepted = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rd_idx < exp_q.size() || out_valid === 1'b1) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) checkOutput("drain_timeout", exp_q.size() - rd_idx, 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) checkOutput("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int a;
    int b;
    int acc;
    int s0;
    int n;
    logic [31:0] snap;

    #1 rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_y_start", 32'(y_start), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    step();
    step();
    rst = 1'b1;
    checkOutput("in_ready_before_edge", 32'(in_ready), 32'd0);
    step();
    checkOutput("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Single job and issue latency
    ready_mode = 1;
    applyStimulus(3, 8, 11);
    checkOutput("lat_e0_y_start", 32'(y_start), 32'd0);
    checkOutput("lat_e0_count", 32'(fifo_count), 32'd1);
    step();
    checkOutput("lat_e1_y_start", 32'(y_start), 32'd1);
    checkOutput("lat_e1_count", 32'(fifo_count), 32'd0);
    wait_idle();
    checkOutput("single_start", start_count, 32'd1);

    // Stalled compute_y: FIFO fills behind the job in flight
    model_hold = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      if (i == 5) checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      if (in_ready === 1'b1) begin
        exp_q.push_back('{a: a, b: b, y: (a + b) % 256});
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    checkOutput("accepted_pairs", acc, FIFO_DEPTH + 1);
    checkOutput("full_count", 32'(fifo_count), FIFO_DEPTH);
    model_hold = 1'b0;
    wait_idle();

    // Back-pressure on the result stream
    ready_mode = 0;
    s0 = start_count;
    applyStimulus(5, 6, 11);
    applyStimulus(7, 9, 16);
    wait_valid();
    snap = 32'({out_valid, out_a, out_b, out_y});
    s0 = s0 + 1;
    checkOutput("first_start_only", start_count, s0);
    for (int i = 0; i < 50; i++) begin
      step();
      checkOutput("held_output", 32'({out_valid, out_a, out_b, out_y}), snap);
    end
    checkOutput("held_no_start", start_count, s0);
    ready_mode = 1;
    wait_idle();
    checkOutput("start_after_handshake", start_count, s0 + 1);

    // Result wider than DATA_W passes through already wrapped
    model_force = 1'b1;
    applyStimulus(16, 1, 257 % 256);
    wait_idle();
    model_force = 1'b0;

    // Random traffic with random consumer back-pressure
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      applyStimulus(a, b, (a + b) % 256);
      repeat ($urandom_range(0, 2)) step();
    end
    ready_mode = 1;
    wait_idle();

    // Asynchronous reset in the middle of WAIT
    model_hold = 1'b1;
    applyStimulus(1, 2, 3);
    applyStimulus(4, 5, 9);
    applyStimulus(6, 7, 13);
    step();
    step();
    checkOutput("pre_reset_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_y_start", 32'(y_start), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_y_ab", 32'({y_a, y_b}), 32'd0);
    step();
    step();
    rst = 1'b1;
    model_hold = 1'b0;
    step();
    s0 = start_count;
    applyStimulus(20, 30, 50);
    wait_idle();
    checkOutput("post_rst_start", start_count, s0 + 1);

    // Watchdog: compute_y never answers
    ready_mode = 0;
    mon_en     = 1'b0;
    model_hold = 1'b1;
    applyStimulus(9, 9, 18);
    n = 0;
    while (y_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("wd_issue", 32'(y_start), 32'd1);
    s0 = start_count;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checkOutput("wd_latency", n, TIMEOUT + 1);
    checkOutput("wd_out_y", 32'(out_y), 32'hFF);
    checkOutput("wd_out_err", 32'(out_err), 32'd1);
    checkOutput("wd_fault", 32'(fault), 32'd1);
    checkOutput("wd_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 1;
    step();
    step();
    step();
    checkOutput("wd_consumed", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_a     = 8'd1;
    in_b     = 8'd1;
    repeat (10) step();
    checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
    checkOutput("halt_count", 32'(fifo_count), 32'd0);
    checkOutput("halt_no_start", start_count, s0);
    checkOutput("halt_fault", 32'(fault), 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    mon_en     = 1'b1;
    model_hold = 1'b0;
    checkOutput("recover_fault", 32'(fault), 32'd0);
    checkOutput("recover_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(100, 200, 300 % 256);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
